servant_spi_slave_mem: RTL and testbench

- SPI responder that emulates the serial FRAM attached to the servant SPI master. It decodes WREN (0x06), WRITE (0x02), READ (0x03) and RDSR (0x05).
- Each command is followed where applicable by a 24-bit address and a byte stream. Data is stored in an internal byte RAM.
- Used in simulation and on-FPGA loopback, so the servant SPI master can be exercised without a physical FRAM.
- Oversamples SCK/SS/MOSI in the system clock domain. No logic is clocked by SCK.

---
 rtl/servant_spi_defs.sv | 28 ++
 rtl/servant_spi_sync_edge.sv | 32 +++
 rtl/servant_spi_slave_mem.sv | 221 ++++++++++++++++++++++
 tb/tb_servant_spi_slave_mem.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/servant_spi_defs.sv
// Shared definitions for the servant SPI master and the FRAM-emulating responder:
// command opcodes, status register layout and the responder state encoding.
package servant_spi_defs;

  localparam logic [7:0] CMD_WRITE_ENABLE = 8'h06;
  localparam logic [7:0] CMD_WRITE_DATA   = 8'h02;
  localparam logic [7:0] CMD_READ_DATA    = 8'h03;
  localparam logic [7:0] CMD_READ_STATUS  = 8'h05;

  localparam int WEL_BIT = 1;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_CMD        = 3'd1;
  localparam logic [2:0] ST_ADDR       = 3'd2;
  localparam logic [2:0] ST_WRITE_DATA = 3'd3;
  localparam logic [2:0] ST_READ_DATA  = 3'd4;
  localparam logic [2:0] ST_STATUS     = 3'd5;
  localparam logic [2:0] ST_DONE       = 3'd6;
  localparam logic [2:0] ST_IGNORE     = 3'd7;

  function automatic logic [7:0] status_byte(input logic wel_bit);
    logic [7:0] s;
    s = 8'h00;
    s[WEL_BIT] = wel_bit;
    return s;
  endfunction

endpackage

// File: rtl/servant_spi_sync_edge.sv
// Two-flop synchronizer for one asynchronous SPI line, plus rise/fall pulses
// derived from the synchronized level and its one-cycle delayed copy.
module servant_spi_sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic meta_q, sync_q, dly_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
      dly_q  <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
      dly_q  <= sync_q;
    end
  end

  assign q    = sync_q;
  assign rise = sync_q & ~dly_q;
  assign fall = ~sync_q & dly_q;

endmodule

// File: rtl/servant_spi_slave_mem.sv
// SPI mode-3 responder emulating a serial FRAM (WREN/WRITE/READ/RDSR) backed by
// an internal byte RAM. All SPI lines are oversampled in the system clock domain.
module servant_spi_slave_mem
  import servant_spi_defs::*;
#(
  parameter int ADDRESS_WIDTH = 24,
  parameter int MEM_ADDR_BITS = 10
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       spi_sck,
  input  logic       spi_ss,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic       wel,
  output logic       busy,
  output logic [2:0] dbg_state
);

  localparam int ADDR_BYTES = ADDRESS_WIDTH / 8;

  logic sck_level_unused, sck_rise, sck_fall;
  logic ss_s, ss_rise, ss_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  // Both SCK (mode 3) and SS idle high, so reset them high to avoid false edges.
  servant_spi_sync_edge #(.RESET_VAL(1'b1)) u_sync_sck (
    .clock(clock), .reset_n(reset_n), .d(spi_sck),
    .q(sck_level_unused), .rise(sck_rise), .fall(sck_fall)
  );
  servant_spi_sync_edge #(.RESET_VAL(1'b1)) u_sync_ss (
    .clock(clock), .reset_n(reset_n), .d(spi_ss),
    .q(ss_s), .rise(ss_rise), .fall(ss_fall)
  );
  servant_spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_mosi (
    .clock(clock), .reset_n(reset_n), .d(spi_mosi),
    .q(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  logic [2:0]               state_q, state_d;
  logic [2:0]               bit_cnt_q, bit_cnt_d;
  logic [6:0]               shift_q, shift_d;
  logic [1:0]               addr_cnt_q, addr_cnt_d;
  logic [MEM_ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]               cmd_q, cmd_d;
  logic                     wel_q, wel_d;
  logic                     miso_q, miso_d;
  logic                     oe_q, oe_d;
  logic [7:0]               out_sr_q, out_sr_d;
  logic [2:0]               out_bit_q, out_bit_d;
  logic                     seen_rise_q, seen_rise_d;
  logic                     load_pend_q, load_pend_d;
  logic [1:0]               settle_q, settle_d;
  logic                     armed_q, armed_d;

  logic [7:0] rx_byte;
  logic       ram_we;
  logic [7:0] ram_rdata_q;
  logic [7:0] ram_q [0:(1<<MEM_ADDR_BITS)-1];

  assign rx_byte = {shift_q, mosi_s};

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    addr_cnt_d  = addr_cnt_q;
    mem_addr_d  = mem_addr_q;
    cmd_d       = cmd_q;
    wel_d       = wel_q;
    miso_d      = miso_q;
    oe_d        = oe_q;
    out_sr_d    = out_sr_q;
    out_bit_d   = out_bit_q;
    seen_rise_d = seen_rise_q;
    load_pend_d = 1'b0;
    ram_we      = 1'b0;
    settle_d    = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
    // A frame may only start once SS has been seen high after the synchronizer
    // flushed, so a reset in the middle of a transfer waits for a fresh SS fall.
    armed_d     = armed_q | ((settle_q == 2'd3) & ss_s);

    if (load_pend_q) begin
      out_sr_d   = ram_rdata_q;
      mem_addr_d = mem_addr_q + 1'b1;
    end

    if (state_q == ST_IDLE) begin
      if (ss_fall && armed_q) begin
        state_d     = ST_CMD;
        bit_cnt_d   = 3'd0;
        seen_rise_d = 1'b0;
      end
    end else begin
      if (sck_rise) begin
        seen_rise_d = 1'b1;
        bit_cnt_d   = bit_cnt_q + 3'd1;
        shift_d     = rx_byte[6:0];
        if (bit_cnt_q == 3'd7) begin
          case (state_q)
            ST_CMD: begin
              cmd_d = rx_byte;
              case (rx_byte)
                CMD_WRITE_ENABLE: begin
                  wel_d   = 1'b1;
                  state_d = ST_DONE;
                end
                CMD_READ_STATUS: begin
                  out_sr_d  = status_byte(wel_q);
                  out_bit_d = 3'd0;
                  state_d   = ST_STATUS;
                end
                CMD_WRITE_DATA, CMD_READ_DATA: begin
                  addr_cnt_d = 2'd0;
                  state_d    = ST_ADDR;
                end
                default: state_d = ST_IGNORE;
              endcase
            end
            ST_ADDR: begin
              // Address bytes shift straight into the RAM pointer; upper bits fall off.
              mem_addr_d = MEM_ADDR_BITS'({mem_addr_q, rx_byte});
              addr_cnt_d = addr_cnt_q + 2'd1;
              if (addr_cnt_q == 2'(ADDR_BYTES - 1)) begin
                if (cmd_q == CMD_READ_DATA) begin
                  state_d     = ST_READ_DATA;
                  load_pend_d = 1'b1;
                  out_bit_d   = 3'd0;
                end else if (wel_q) begin
                  state_d = ST_WRITE_DATA;
                end else begin
                  state_d = ST_IGNORE;
                end
              end
            end
            ST_WRITE_DATA: begin
              ram_we     = 1'b1;
              mem_addr_d = mem_addr_q + 1'b1;
            end
            default: ;
          endcase
        end
      end

      if (sck_fall && seen_rise_q &&
          (state_q == ST_READ_DATA || state_q == ST_STATUS)) begin
        miso_d    = out_sr_q[7];
        oe_d      = 1'b1;
        out_bit_d = out_bit_q + 3'd1;
        if (out_bit_q == 3'd7) begin
          // ram_rdata_q already holds the byte at mem_addr_q, i.e. the next one.
          if (state_q == ST_READ_DATA) begin
            out_sr_d   = ram_rdata_q;
            mem_addr_d = mem_addr_q + 1'b1;
          end else begin
            out_sr_d = status_byte(wel_q);
          end
        end else begin
          out_sr_d = {out_sr_q[6:0], 1'b0};
        end
      end

      if (ss_rise) begin
        if (state_d == ST_WRITE_DATA) wel_d = 1'b0;
        state_d = ST_IDLE;
        oe_d    = 1'b0;
        miso_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 7'd0;
      addr_cnt_q  <= 2'd0;
      mem_addr_q  <= '0;
      cmd_q       <= 8'd0;
      wel_q       <= 1'b0;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
      out_sr_q    <= 8'd0;
      out_bit_q   <= 3'd0;
      seen_rise_q <= 1'b0;
      load_pend_q <= 1'b0;
      settle_q    <= 2'd0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      addr_cnt_q  <= addr_cnt_d;
      mem_addr_q  <= mem_addr_d;
      cmd_q       <= cmd_d;
      wel_q       <= wel_d;
      miso_q      <= miso_d;
      oe_q        <= oe_d;
      out_sr_q    <= out_sr_d;
      out_bit_q   <= out_bit_d;
      seen_rise_q <= seen_rise_d;
      load_pend_q <= load_pend_d;
      settle_q    <= settle_d;
      armed_q     <= armed_d;
    end
  end

  // RAM is never reset so its contents survive reset_n pulses.
  always_ff @(posedge clock) begin
    if (ram_we) ram_q[mem_addr_q] <= rx_byte;
    ram_rdata_q <= ram_q[mem_addr_d];
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = oe_q;
  assign wel         = wel_q;
  assign busy        = ~ss_s;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_servant_spi_slave_mem.sv
// Directed SPI-master bench for servant_spi_slave_mem with a byte-level memory
// model and an expected-byte queue for everything read back over MISO.
module tb_servant_spi_slave_mem;

  localparam int HALF = 6;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       spi_sck = 1'b1;
  logic       spi_ss = 1'b1;
  logic       spi_mosi = 1'b0;
  logic       spi_miso, spi_miso_oe, wel, busy;
  logic [2:0] dbg_state;

  servant_spi_slave_mem #(.ADDRESS_WIDTH(24), .MEM_ADDR_BITS(10)) dut (
    .clock(clock), .reset_n(reset_n),
    .spi_sck(spi_sck), .spi_ss(spi_ss), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .wel(wel), .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] exp_q[$];
  logic [7:0] wr_buf[$];
  logic [7:0] model_mem [0:1023];
  logic       model_wel = 1'b0;
  logic [7:0] rx_unused;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic spi_bit(input logic b, output logic r);
    @(negedge clock);
    spi_sck  = 1'b0;
    spi_mosi = b;
    repeat (HALF) @(negedge clock);
    r = spi_miso;
    spi_sck = 1'b1;
    repeat (HALF) @(negedge clock);
  endtask

  task automatic spi_xfer(input logic [7:0] tx, output logic [7:0] rx);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], b);
      rx[i] = b;
    end
  endtask

  task automatic ss_begin();
    @(negedge clock);
    spi_ss = 1'b0;
    repeat (HALF) @(negedge clock);
  endtask

  task automatic ss_end();
    repeat (HALF) @(negedge clock);
    spi_ss = 1'b1;
    repeat (10) @(negedge clock);
  endtask

  task automatic send_addr(input logic [23:0] addr);
    spi_xfer(addr[23:16], rx_unused);
    spi_xfer(addr[15:8], rx_unused);
    spi_xfer(addr[7:0], rx_unused);
  endtask

  task automatic cmd_wren();
    ss_begin();
    check("busy_in_frame", 8'(busy), 8'd1);
    spi_xfer(8'h06, rx_unused);
    ss_end();
    model_wel = 1'b1;
    check("wel_after_wren", 8'(wel), 8'(model_wel));
  endtask

  task automatic cmd_write(input logic [23:0] addr);
    logic [9:0] a;
    ss_begin();
    spi_xfer(8'h02, rx_unused);
    send_addr(addr);
    a = addr[9:0];
    foreach (wr_buf[i]) begin
      spi_xfer(wr_buf[i], rx_unused);
      if (model_wel) model_mem[a] = wr_buf[i];
      a = a + 10'd1;
    end
    ss_end();
    model_wel = 1'b0;
    check("wel_after_write", 8'(wel), 8'(model_wel));
    check("oe_after_write", 8'(spi_miso_oe), 8'd0);
  endtask

  task automatic cmd_read(input logic [23:0] addr, input int n);
    logic [9:0] a;
    logic [7:0] rx;
    a = addr[9:0];
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(model_mem[a]);
      a = a + 10'd1;
    end
    ss_begin();
    spi_xfer(8'h03, rx_unused);
    send_addr(addr);
    check("oe_during_addr", 8'(spi_miso_oe), 8'd0);
    for (int i = 0; i < n; i++) begin
      spi_xfer(8'h00, rx);
      check("oe_during_data", 8'(spi_miso_oe), 8'd1);
      check("read_byte", rx, exp_q.pop_front());
    end
    ss_end();
    check("oe_after_read", 8'(spi_miso_oe), 8'd0);
  endtask

  task automatic cmd_rdsr();
    logic [7:0] rx;
    exp_q.push_back({6'b0, model_wel, 1'b0});
    exp_q.push_back({6'b0, model_wel, 1'b0});
    ss_begin();
    spi_xfer(8'h05, rx_unused);
    check("oe_rdsr_cmd", 8'(spi_miso_oe), 8'd0);
    for (int i = 0; i < 2; i++) begin
      spi_xfer(8'h00, rx);
      check("oe_rdsr_data", 8'(spi_miso_oe), 8'd1);
      check("rdsr_byte", rx, exp_q.pop_front());
    end
    ss_end();
    check("oe_after_rdsr", 8'(spi_miso_oe), 8'd0);
  endtask

  initial begin
    logic [7:0] rx;
    logic       b;

    // clock / reset
    repeat (4) @(negedge clock);
    check("rst_miso", 8'(spi_miso), 8'd0);
    check("rst_oe", 8'(spi_miso_oe), 8'd0);
    reset_n = 1'b1;
    repeat (10) @(negedge clock);
    check("rst_wel", 8'(wel), 8'd0);
    check("rst_busy", 8'(busy), 8'd0);
    check("rst_state", 8'(dbg_state), 8'd0);

    // status register: after reset, after WREN, after a completed WRITE
    cmd_rdsr();
    cmd_wren();
    cmd_rdsr();
    wr_buf = '{8'h3C};
    cmd_write(24'h000100);
    cmd_rdsr();

    // write then read
    cmd_wren();
    wr_buf = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    cmd_write(24'h000010);
    cmd_read(24'h000010, 4);

    // write blocked without WREN
    cmd_wren();
    wr_buf = '{8'h00};
    cmd_write(24'h000020);
    wr_buf = '{8'h55};
    cmd_write(24'h000020);
    cmd_read(24'h000020, 1);

    // address wrap; upper address bits ignored on the read
    cmd_wren();
    wr_buf = '{8'h11, 8'h22};
    cmd_write(24'h0003FF);
    cmd_read(24'h0003FF, 2);
    cmd_read(24'hAB0000, 1);

    // abort mid-byte
    cmd_wren();
    wr_buf = '{8'h5A};
    cmd_write(24'h000041);
    cmd_wren();
    ss_begin();
    spi_xfer(8'h02, rx_unused);
    send_addr(24'h000040);
    spi_xfer(8'h77, rx_unused);
    model_mem[10'h040] = 8'h77;
    for (int i = 7; i >= 4; i--) spi_bit(i == 7, b);
    ss_end();
    model_wel = 1'b0;
    check("wel_after_abort", 8'(wel), 8'd0);
    cmd_read(24'h000040, 2);

    // reset in the middle of the second byte of a READ
    cmd_wren();
    wr_buf = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    cmd_write(24'h000080);
    ss_begin();
    spi_xfer(8'h03, rx_unused);
    send_addr(24'h000080);
    spi_xfer(8'h00, rx);
    check("pre_reset_byte", rx, model_mem[10'h080]);
    for (int i = 0; i < 3; i++) spi_bit(1'b0, b);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("reset_oe", 8'(spi_miso_oe), 8'd0);
    check("reset_miso", 8'(spi_miso), 8'd0);
    check("reset_state", 8'(dbg_state), 8'd0);
    model_wel = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    spi_xfer(8'h03, rx_unused);
    check("no_resume_oe", 8'(spi_miso_oe), 8'd0);
    check("no_resume_state", 8'(dbg_state), 8'd0);
    ss_end();
    check("wel_after_reset", 8'(wel), 8'd0);
    cmd_read(24'h000080, 4);

    // final report
    if (exp_q.size() != 0) check("scoreboard_drained", 8'(exp_q.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
